// File: rtl/mont_stream_io.sv
// mont_stream_io: 32-bit word stream front/back end for the montgomery core.
// Loads A,B,M (LS word first), pulses mont_start, waits for mont_done,
// captures the result and streams it out LS word first.
// Ports: clk, resetn (async, active-low); s_data/s_valid/s_ready input
// stream; m_data/m_valid/m_ready output stream; mont_a/b/m operands,
// mont_start, mont_result, mont_done to/from core; busy; cycle_count.
// Optional: define MONT_STREAM_CYCLE_COUNT_EN to build the latency counter.
module mont_stream_io #(
  parameter int W = 32,
  parameter int N = 512
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] mont_a,
  output logic [N-1:0] mont_b,
  output logic [N-1:0] mont_m,
  output logic         mont_start,
  input  logic [N-1:0] mont_result,
  input  logic         mont_done,
  output logic         busy,
  output logic [31:0]  cycle_count
);

  localparam int WORDS = N / W;
  localparam int CW = $clog2(3 * WORDS);
  localparam int IW = $clog2(WORDS);

  localparam logic [CW-1:0] ONE_C  = CW'(WORDS);
  localparam logic [CW-1:0] TWO_C  = CW'(2 * WORDS);
  localparam logic [CW-1:0] LAST_C = CW'(3 * WORDS - 1);
  localparam logic [IW-1:0] LAST_I = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  a_q, b_q, m_q, res_q;

  logic s_fire;
  logic m_fire;
  logic load_last;
  logic drain_last;
  logic capture;

  assign s_fire     = s_valid & s_ready;
  assign m_fire     = m_valid & m_ready;
  assign load_last  = s_fire && (wcnt_q == LAST_C);
  assign drain_last = m_fire && (idx_q == LAST_I);
  assign capture    = (state_q == WAIT) && mont_done;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (load_last) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (mont_done) state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Output decode
  always_comb begin
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    mont_start = 1'b0;
    busy       = 1'b0;
    unique case (1'b1)
      (state_q == LOAD):  s_ready = 1'b1;
      (state_q == START): begin
        mont_start = 1'b1;
        busy       = 1'b1;
      end
      (state_q == WAIT):  busy = 1'b1;
      (state_q == DRAIN): m_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (load_last) begin
      wcnt_d = '0;
    end else if (s_fire) begin
      wcnt_d = wcnt_q + CW'(1);
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (drain_last) begin
      idx_d = '0;
    end else if (m_fire) begin
      idx_d = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wcnt_q <= '0;
      idx_q  <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      idx_q  <= idx_d;
    end
  end

  // Operands shift in from the top, so after WORDS accepted words the
  // first (LS) word lands in bits [W-1:0] and word k in [W*k+W-1:W*k].
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
    end else if (s_fire) begin
      if (wcnt_q < ONE_C) begin
        a_q <= {s_data, a_q[N-1:W]};
      end else if (wcnt_q < TWO_C) begin
        b_q <= {s_data, b_q[N-1:W]};
      end else begin
        m_q <= {s_data, m_q[N-1:W]};
      end
    end
  end

  // Result shifts down on each accepted beat; m_data is always the
  // bottom word, so it only moves when a beat is taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_q <= '0;
    end else if (capture) begin
      res_q <= mont_result;
    end else if (m_fire) begin
      res_q <= {{W{1'b0}}, res_q[N-1:W]};
    end
  end

  assign mont_a = a_q;
  assign mont_b = b_q;
  assign mont_m = m_q;
  assign m_data = res_q[W-1:0];

`ifdef MONT_STREAM_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == START) begin
      cyc_d = '0;
    end else if ((state_q == WAIT) && (cyc_q != '1)) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_mont_stream_io.sv
// tb_mont_stream_io: directed self-checking bench for mont_stream_io.
// Drives operand words, models the core's done/result, checks outputs.
module tb_mont_stream_io;

  logic         clk;
  logic         resetn;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic [511:0] mont_a;
  logic [511:0] mont_b;
  logic [511:0] mont_m;
  logic         mont_start;
  logic [511:0] mont_result;
  logic         mont_done;
  logic         busy;
  logic [31:0]  cycle_count;

  int cmp;
  int err;

  mont_stream_io dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .mont_a      (mont_a),
    .mont_b      (mont_b),
    .mont_m      (mont_m),
    .mont_start  (mont_start),
    .mont_result (mont_result),
    .mont_done   (mont_done),
    .busy        (busy),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wsel(
    input logic [511:0] a,
    input logic [511:0] b,
    input logic [511:0] m,
    input int i
  );
    logic [511:0] v;
    if (i < 16) v = a;
    else if (i < 32) v = b;
    else v = m;
    return v[(i % 16) * 32 +: 32];
  endfunction

  // Plain 48-word load, s_valid held high; returns in START.
  task automatic load_ops(
    input logic [511:0] a,
    input logic [511:0] b,
    input logic [511:0] m
  );
    for (int i = 0; i < 48; i++) begin
      s_valid = 1'b1;
      s_data  = wsel(a, b, m, i);
      tick();
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  // Core model: done in the lat-th WAIT cycle (called in WAIT cycle 1).
  task automatic core(input int lat, input logic [511:0] res);
    for (int i = 1; i < lat; i++) tick();
    mont_done   = 1'b1;
    mont_result = res;
    tick();
    mont_done   = 1'b0;
    mont_result = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 ||
        mont_start !== 1'b0 || busy !== 1'b0) begin
      err++;
      $display("FAIL reset_ctrl: rdy=%b val=%b st=%b busy=%b want 1000",
               s_ready, m_valid, mont_start, busy);
    end
    cmp++;
    if (mont_a !== '0 || mont_b !== '0 || mont_m !== '0 ||
        m_data !== '0 || cycle_count !== '0) begin
      err++;
      $display("FAIL reset_data: a/b/m/m_data/cc not all zero (cc=%h)",
               cycle_count);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_load_start();
    logic [511:0] a, b, m;
    a = 512'd1;
    b = 512'd2;
    m = '1;
    m[3:0] = 4'h1;
    cmp++;
    if (mont_start !== 1'b0 || s_ready !== 1'b1) begin
      err++;
      $display("FAIL pre_load: start=%b rdy=%b want 0 1",
               mont_start, s_ready);
    end
    load_ops(a, b, m);
    cmp++;
    if (mont_start !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
      err++;
      $display("FAIL start_cycle: start=%b rdy=%b busy=%b want 1 0 1",
               mont_start, s_ready, busy);
    end
    cmp++;
    if (mont_a !== a || mont_b !== b || mont_m !== m) begin
      err++;
      $display("FAIL operands: a=%h b=%h m_lo=%h want 1 2 fff1",
               mont_a[31:0], mont_b[31:0], mont_m[31:0]);
    end
    tick();
    cmp++;
    if (mont_start !== 1'b0 || s_ready !== 1'b0 ||
        busy !== 1'b1 || m_valid !== 1'b0) begin
      err++;
      $display("FAIL wait_entry: start=%b rdy=%b busy=%b val=%b",
               mont_start, s_ready, busy, m_valid);
    end
  endtask

  task automatic test_drain();
    logic [511:0] res;
    int bad;
    for (int k = 0; k < 16; k++) res[k*32 +: 32] = k;
    core(10, res);
    bad = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (m_valid !== 1'b1 || m_data !== i) begin
        bad++;
        $display("FAIL drain_beat%0d: val=%b data=%h want 1 %h",
                 i, m_valid, m_data, i);
      end
      tick();
    end
    cmp++;
    if (bad != 0) err++;
    cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
      err++;
      $display("FAIL after_drain: rdy=%b val=%b busy=%b want 1 0 0",
               s_ready, m_valid, busy);
    end
    cmp++;
    if (mont_a !== 512'd1 || mont_b !== 512'd2) begin
      err++;
      $display("FAIL op_stable: a=%h b=%h", mont_a[31:0], mont_b[31:0]);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [511:0] res;
    logic [31:0]  held;
    logic         stalled;
    int got, bad, c;
    for (int k = 0; k < 16; k++) res[k*32 +: 32] = 32'h11111111 * k;
    load_ops('0, '0, '0);
    tick();
    core(4, res);
    got = 0;
    bad = 0;
    stalled = 1'b0;
    held = '0;
    c = 0;
    while (got < 16 && c < 100) begin
      m_ready = (c % 3 == 0);
      if (m_valid) begin
        if (stalled && m_data !== held) begin
          bad++;
          $display("FAIL bp_hold: data=%h want %h", m_data, held);
        end
        if (m_ready) begin
          if (m_data !== 32'h11111111 * got) begin
            bad++;
            $display("FAIL bp_order%0d: data=%h want %h",
                     got, m_data, 32'h11111111 * got);
          end
          got++;
        end
        stalled = !m_ready;
        held = m_data;
      end
      tick();
      c++;
    end
    m_ready = 1'b0;
    cmp++;
    if (bad != 0 || got != 16) begin
      err++;
      $display("FAIL backpressure: got=%0d errs=%0d want 16 0", got, bad);
    end
    cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      err++;
      $display("FAIL bp_end: rdy=%b val=%b want 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_gaps_stray();
    logic [511:0] a, b, m;
    int i, c, bad;
    for (int k = 0; k < 16; k++) begin
      a[k*32 +: 32] = 32'h0A000000 + k;
      b[k*32 +: 32] = 32'h0B000000 + k;
      m[k*32 +: 32] = 32'h0C000000 + k;
    end
    i = 0;
    c = 0;
    bad = 0;
    while (i < 48 && c < 100) begin
      if (c % 3 == 2) begin
        s_valid     = 1'b0;
        s_data      = 32'hDEADBEEF;
        mont_done   = (c == 20);
        mont_result = '1;
        tick();
        mont_done = 1'b0;
        if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
          bad++;
          $display("FAIL gap_state%0d: rdy=%b busy=%b val=%b",
                   c, s_ready, busy, m_valid);
        end
      end else begin
        s_valid = 1'b1;
        s_data  = wsel(a, b, m, i);
        tick();
        i++;
      end
      c++;
    end
    s_valid = 1'b0;
    cmp++;
    if (bad != 0) err++;
    cmp++;
    if (mont_a !== a || mont_b !== b || mont_m !== m ||
        mont_start !== 1'b1) begin
      err++;
      $display("FAIL gap_ops: a0=%h b15=%h m7=%h start=%b",
               mont_a[31:0], mont_b[511:480], mont_m[255:224], mont_start);
    end
    tick();
    core(2, '0);
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    m_ready = 1'b0;
    cmp++;
    if (s_ready !== 1'b1) begin
      err++;
      $display("FAIL gap_done: rdy=%b want 1", s_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [511:0] res;
    int bad;
    load_ops({16{32'h12345678}}, {16{32'h9ABCDEF0}}, '1);
    tick();
    tick();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    cmp++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1 ||
        mont_a !== '0 || mont_b !== '0 || mont_m !== '0 ||
        cycle_count !== '0) begin
      err++;
      $display("FAIL rst_async: busy=%b val=%b rdy=%b a0=%h cc=%h",
               busy, m_valid, s_ready, mont_a[31:0], cycle_count);
    end
    tick();
    resetn = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) res[k*32 +: 32] = 32'hC0DE0000 + k;
    load_ops(512'd7, 512'd9, 512'd11);
    cmp++;
    if (mont_start !== 1'b1 || mont_a !== 512'd7 ||
        mont_b !== 512'd9 || mont_m !== 512'd11) begin
      err++;
      $display("FAIL rst_reload: start=%b a=%h b=%h m=%h", mont_start,
               mont_a[31:0], mont_b[31:0], mont_m[31:0]);
    end
    tick();
    core(5, res);
    m_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_valid !== 1'b1 || m_data !== 32'hC0DE0000 + i) begin
        bad++;
        $display("FAIL rst_drain%0d: val=%b data=%h", i, m_valid, m_data);
      end
      tick();
    end
    m_ready = 1'b0;
    cmp++;
    if (bad != 0 || s_ready !== 1'b1) begin
      err++;
      $display("FAIL rst_txn: errs=%0d rdy=%b", bad, s_ready);
    end
  endtask

  task automatic test_cycle_count();
    logic [31:0] want;
`ifdef MONT_STREAM_CYCLE_COUNT_EN
    want = 32'd300;
`else
    want = 32'd0;
`endif
    load_ops(512'd3, 512'd4, 512'd5);
    tick();
    core(300, '0);
    cmp++;
    if (cycle_count !== want || m_valid !== 1'b1) begin
      err++;
      $display("FAIL cycle_count: got=%0d val=%b want %0d 1",
               cycle_count, m_valid, want);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    m_ready = 1'b0;
    tick();
    cmp++;
    if (cycle_count !== want || s_ready !== 1'b1) begin
      err++;
      $display("FAIL cc_hold: got=%0d rdy=%b want %0d 1",
               cycle_count, s_ready, want);
    end
  endtask

  initial begin
    cmp = 0;
    err = 0;
    resetn = 1'b0;
    s_data = '0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    mont_result = '0;
    mont_done = 1'b0;
    test_reset();
    test_load_start();
    test_drain();
    test_backpressure();
    test_gaps_stray();
    test_reset_mid_wait();
    test_cycle_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
